fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the program counter.
- Reads the current PC index and issues a req/ack read to instruction memory.
- Holds the fetched word in a one-entry output slot with valid/ready toward decode.
- Drives the PC's enable / inc-or-set / new-value controls: increments after each accepted fetch, loads the target on a branch/jump redirect.

Parameters:
- ADDR_W, 16, width of PC index, memory address and redirect target
- DATA_W, 16, instruction word width

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low
- pc_index  in  ADDR_W  current PC value
- pc_enable  out  1  PC update strobe, sampled by PC on the same edge
- pc_inc_or_set  out  1  0 = increment, 1 = load pc_new_value
- pc_new_value  out  ADDR_W  PC load value; always equals redirect_target
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  read address, stable while imem_req = 1
- imem_ack  in  1  read complete; imem_data valid this cycle
- imem_data  in  DATA_W  read data
- instr  out  DATA_W  fetched instruction
- instr_pc  out  ADDR_W  address the instruction was fetched from
- instr_valid  out  1  output slot full
- instr_ready  in  1  decode accepts slot this cycle
- redirect  in  1  branch/jump taken; flush and restart at redirect_target
- redirect_target  in  ADDR_W  new fetch address
- halt  in  1  suppress starting new fetches
- fetch_busy  out  1  memory transaction outstanding (state FETCH or DRAIN)

Behaviour:
- Clock and reset: reset is synchronous, active-low; clock is clock.
- Reset (reset = 0 at an edge):
  - state = IDLE; instr, instr_pc, instr_valid and drain_addr = 0.
  - pc_enable is forced 0 while reset = 0.
- Memory protocol:
  - A transaction completes on any cycle with imem_req = 1 and imem_ack = 1.
  - If req stays high the next cycle, that starts a new transaction.
  - req is never dropped before ack.
- PC control is combinational from state, imem_ack and redirect. The PC sees the update at the same edge, and the new pc_index appears one cycle later.
- IDLE:
  - req = 0, instr_valid = 0.
  - redirect: pc_enable = 1, pc_inc_or_set = 1; stay IDLE.
  - Else if halt = 0: go to FETCH.
- FETCH:
  - req = 1, imem_addr = pc_index.
  - ack and redirect: discard data; pc set to target; go to FETCH if halt = 0, else IDLE.
  - ack, no redirect: instr <= imem_data, instr_pc <= pc_index, instr_valid <= 1; pc_enable = 1, pc_inc_or_set = 0; go to HOLD.
  - redirect, no ack: pc set to target; drain_addr <= pc_index; go to DRAIN.
  - Neither: stay FETCH.
- DRAIN:
  - req = 1, imem_addr = drain_addr.
  - Any redirect: pc set to the new target; stay until ack (last redirect wins).
  - On ack: discard data; go to FETCH if halt = 0, else IDLE.
- HOLD:
  - req = 0, instr_valid = 1.
  - redirect: instr_valid <= 0 (flushed, even if instr_ready = 1); pc set; go to FETCH if halt = 0, else IDLE.
  - Else if instr_ready: instr_valid <= 0; go to FETCH if halt = 0, else IDLE.
- Priority: redirect beats increment in every state. halt never aborts an in-flight transaction.
- Throughput: one instruction per 2 cycles minimum with zero-wait memory and instr_ready held high.
- Arithmetic: no arithmetic in this block (PC performs the increment). Wrap from 0xFFFF to 0 is the PC's, transparent here.
- instr/instr_pc hold their value whenever not loading.

Decomposition:
- Shared cpu package: state enum (IDLE, FETCH, HOLD, DRAIN) and the constants PC_INC = 1'b0, PC_SET = 1'b1, reused by the PC and the branch unit.
- Single flat module; no sub-module needed.

Test Plan:
- Zero-wait memory returning mem[a] = a ^ 16'hA5A5, instr_ready = 1, start PC 0 → instr sequence 0xA5A5, 0xA5A4, 0xA5A7 with instr_pc 0, 1, 2; one pc_enable pulse (inc_or_set = 0) per ack.
- Memory ack delayed 3 cycles → imem_req and imem_addr = 0x0010 held stable 4 cycles; instr_valid rises the cycle after ack.
- redirect to 0x0040 while HOLD with instr_ready = 1 → slot flushed (never consumed); pc_inc_or_set = 1, pc_new_value = 0x0040; next imem_addr = 0x0040.
- redirect to 0x0080 during pending fetch of 0x0005 → DRAIN keeps imem_addr = 0x0005 until ack; data discarded; next fetch at 0x0080.
- instr_ready = 0 for 5 cycles → instr and instr_pc stable, imem_req = 0; halt = 1 then ready → state IDLE, no request issued.
- reset = 0 mid-transaction → next cycle instr_valid = 0, imem_req = 0, pc_enable = 0, fetch_busy = 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared CPU definitions: fetch-stage state encoding and the
//               PC control constants also used by the PC and branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

  // Fetch-stage state encoding (explicit 2-bit width)
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // PC control: select between increment and load of a new value
  localparam logic PC_INC = 1'b0;
  localparam logic PC_SET = 1'b1;

  // True for states that own an outstanding memory transaction
  function automatic logic state_is_busy(input fetch_state_t s);
    return (s == FETCH) || (s == DRAIN);
  endfunction

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Issues req/ack reads at the current
//               PC, holds the fetched word in a one-entry valid/ready slot
//               toward decode, and steers the PC (increment after each
//               accepted fetch, load on a branch/jump redirect).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_index,
  output logic              pc_enable,
  output logic              pc_inc_or_set,
  output logic [ADDR_W-1:0] pc_new_value,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  output logic              fetch_busy
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;

  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_drain_addr;

  logic              w_pc_enable;
  logic              w_pc_sel;
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;

  // Datapath events, decoded from the current state and handshakes
  logic              w_load_slot;
  logic              w_free_slot;
  logic              w_capture_drain;
  fetch_state_t      w_resume_state;

  // Completed read with no redirect: the word lands in the output slot
  assign w_load_slot     = (r_state == FETCH) && imem_ack && !redirect;
  // Slot leaves HOLD either by being consumed or by being flushed
  assign w_free_slot     = (r_state == HOLD) && (redirect || instr_ready);
  // Redirect with the read still in flight: remember its address for DRAIN
  assign w_capture_drain = (r_state == FETCH) && redirect && !imem_ack;
  // Where to go once the current fetch cycle is finished
  assign w_resume_state  = halt ? IDLE : FETCH;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; halt only gates the start of new fetches
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (!redirect && !halt) begin
          w_state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack && redirect) begin
          w_state_next = w_resume_state;
        end else if (imem_ack) begin
          w_state_next = HOLD;
        end else if (redirect) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          w_state_next = w_resume_state;
        end
      end
      HOLD: begin
        if (redirect || instr_ready) begin
          w_state_next = w_resume_state;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: memory request/address and PC control (redirect wins)
  always_comb begin
    w_pc_enable = 1'b0;
    w_pc_sel    = PC_INC;
    w_req       = 1'b0;
    w_addr      = pc_index;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_pc_enable = 1'b1;
          w_pc_sel    = PC_SET;
        end
      end
      FETCH: begin
        w_req = 1'b1;
        if (redirect) begin
          w_pc_enable = 1'b1;
          w_pc_sel    = PC_SET;
        end else if (imem_ack) begin
          w_pc_enable = 1'b1;
          w_pc_sel    = PC_INC;
        end
      end
      DRAIN: begin
        // Keep presenting the abandoned address until memory answers
        w_req  = 1'b1;
        w_addr = r_drain_addr;
        if (redirect) begin
          w_pc_enable = 1'b1;
          w_pc_sel    = PC_SET;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_enable = 1'b1;
          w_pc_sel    = PC_SET;
        end
      end
      default: begin
        w_pc_enable = 1'b0;
      end
    endcase
  end

  // Output slot and drain address; instr/instr_pc hold unless loading
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_drain_addr  <= '0;
    end else begin
      if (w_load_slot) begin
        r_instr       <= imem_data;
        r_instr_pc    <= pc_index;
        r_instr_valid <= 1'b1;
      end else if (w_free_slot) begin
        r_instr_valid <= 1'b0;
      end
      if (w_capture_drain) begin
        r_drain_addr <= pc_index;
      end
    end
  end

  // The PC must never move while the core is held in reset
  assign pc_enable     = w_pc_enable & reset;
  assign pc_inc_or_set = w_pc_sel;
  assign pc_new_value  = redirect_target;
  assign imem_req      = w_req;
  assign imem_addr     = w_addr;
  assign instr         = r_instr;
  assign instr_pc      = r_instr_pc;
  assign instr_valid   = r_instr_valid;
  assign fetch_busy    = state_is_busy(r_state);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A behavioural PC and a
//               latency-programmable memory surround the DUT; expected decode
//               words are queued by the stimulus and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc_index;
  logic        pc_enable;
  logic        pc_inc_or_set;
  logic [15:0] pc_new_value;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        halt;
  logic        fetch_busy;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mem_lat = 0;
  int   en_cnt  = 0;
  int   set_cnt = 0;
  logic        tb_pc_load;
  logic [15:0] tb_pc_val;

  fetch_unit #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_index        (pc_index),
    .pc_enable       (pc_enable),
    .pc_inc_or_set   (pc_inc_or_set),
    .pc_new_value    (pc_new_value),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .halt            (halt),
    .fetch_busy      (fetch_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural program counter driven by the DUT's PC controls
  always @(posedge clock) begin
    if (tb_pc_load) pc_index <= tb_pc_val;
    else if (pc_enable === 1'b1) pc_index <= (pc_inc_or_set === 1'b1) ? pc_new_value : pc_index + 16'd1;
  end

  // Memory: ack after mem_lat wait cycles, data = addr ^ 0xA5A5
  initial begin
    int wcnt;
    wcnt = 0;
    imem_ack  = 1'b0;
    imem_data = 16'h0;
    forever begin
      @(negedge clock);
      if (imem_req === 1'b1) begin
        if (wcnt >= mem_lat) begin
          imem_ack  = 1'b1;
          imem_data = imem_addr ^ 16'hA5A5;
          wcnt      = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // Scoreboard monitor: compare every word decode actually takes
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (reset === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1 && redirect !== 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got instr=0x%0h pc=0x%0h, required none", instr, instr_pc);
        end else begin
          e = exp_q.pop_front();
          if (instr !== e.word || instr_pc !== e.pc) begin
            bad++;
            $display("FAIL sb_word: got instr=0x%0h pc=0x%0h, required instr=0x%0h pc=0x%0h",
                     instr, instr_pc, e.word, e.pc);
          end
        end
      end
    end
  end

  // PC strobe observer
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (pc_enable === 1'b1) begin
        en_cnt++;
        if (pc_inc_or_set === 1'b1) set_cnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] p);
    exp_t e;
    e.word = w;
    e.pc   = p;
    exp_q.push_back(e);
  endtask

  task automatic load_pc(input logic [15:0] v);
    tb_pc_load = 1'b1;
    tb_pc_val  = v;
    tick();
    tb_pc_load = 1'b0;
  endtask

  initial begin
    int en0, set0, first, last, n, got;
    reset = 1'b0; halt = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
    redirect_target = 16'h0; tb_pc_load = 1'b1; tb_pc_val = 16'h0;
    repeat (3) tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_busy", fetch_busy, 0);
    chk("rst_pcen", pc_enable, 0);
    reset = 1'b1; tb_pc_load = 1'b0;
    tick();

    // Zero-wait streaming from PC 0
    mem_lat = 0; instr_ready = 1'b1;
    load_pc(16'h0000);
    push(16'hA5A5, 16'h0000); push(16'hA5A4, 16'h0001); push(16'hA5A7, 16'h0002);
    en0 = en_cnt; set0 = set_cnt; first = -1; last = -1; got = 0;
    halt = 1'b0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      tick();
      if (instr_valid === 1'b1 && instr_pc === 16'h0 && first < 0) first = i;
      if (instr_valid === 1'b1 && instr_pc === 16'h2) begin
        halt = 1'b1; got = 1; last = i;
      end
    end
    chk("t1_reached", got, 1);
    chk("t1_spacing", last - first, 4);
    tick(); tick();
    chk("t1_idle_req", imem_req, 0);
    chk("t1_pc_pulses", en_cnt - en0, 3);
    chk("t1_pc_sets", set_cnt - set0, 0);

    // Three wait states at 0x0010, then decode stalls
    instr_ready = 1'b0; mem_lat = 3;
    load_pc(16'h0010);
    push(16'hA5B5, 16'h0010);
    halt = 1'b0;
    tick();
    halt = 1'b1;
    n = 0; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      if (imem_req === 1'b1 && imem_addr === 16'h0010) n++;
      if (imem_ack === 1'b1) got = 1;
      else tick();
    end
    chk("t2_stable_cycles", n, 4);
    chk("t2_valid_at_ack", instr_valid, 0);
    tick();
    chk("t2_valid_after", instr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t5_instr_hold", instr, 16'hA5B5);
      chk("t5_pc_hold", instr_pc, 16'h0010);
      chk("t5_req_low", imem_req, 0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk("t5_halt_valid", instr_valid, 0);
    chk("t5_halt_busy", fetch_busy, 0);
    tick(); tick();
    chk("t5_no_req", imem_req, 0);

    // Redirect while holding a word that decode is ready to take
    instr_ready = 1'b0; mem_lat = 0;
    load_pc(16'h0020);
    halt = 1'b0;
    tick(); tick();
    chk("t3_hold_valid", instr_valid, 1);
    chk("t3_hold_instr", instr, 16'hA585);
    push(16'hA5E5, 16'h0040);
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 16'h0040;
    #1;
    chk("t3_pcen", pc_enable, 1);
    chk("t3_pcset", pc_inc_or_set, 1);
    chk("t3_newval", pc_new_value, 16'h0040);
    tick();
    redirect = 1'b0;
    chk("t3_flushed", instr_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 16'h0040);
    halt = 1'b1;
    tick(); tick();
    chk("t3_idle_req", imem_req, 0);

    // Redirect while the read of 0x0005 is pending
    mem_lat = 3;
    load_pc(16'h0005);
    push(16'hA525, 16'h0080);
    halt = 1'b0;
    tick();
    chk("t4_addr_pend", imem_addr, 16'h0005);
    redirect = 1'b1; redirect_target = 16'h0080;
    #1;
    chk("t4_pcset", pc_inc_or_set, 1);
    chk("t4_pcen", pc_enable, 1);
    tick();
    redirect = 1'b0;
    n = 0; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      chk("t4_drain_addr", imem_addr, 16'h0005);
      chk("t4_drain_busy", fetch_busy, 1);
      n++;
      if (imem_ack === 1'b1) got = 1;
      else tick();
    end
    chk("t4_drain_cycles", n, 3);
    tick();
    chk("t4_refetch_addr", imem_addr, 16'h0080);
    chk("t4_refetch_req", imem_req, 1);
    chk("t4_no_valid", instr_valid, 0);
    halt = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      if (instr_valid === 1'b1) got = 1;
      else tick();
    end
    chk("t4_got_word", got, 1);
    tick(); tick();
    chk("t4_idle_req", imem_req, 0);

    // Reset in the middle of a transaction
    load_pc(16'h0030);
    halt = 1'b0;
    tick(); tick();
    chk("t6_busy_before", fetch_busy, 1);
    reset = 1'b0; redirect = 1'b1; redirect_target = 16'h0099;
    #1;
    chk("t6_pcen_forced", pc_enable, 0);
    tick();
    chk("t6_valid", instr_valid, 0);
    chk("t6_req", imem_req, 0);
    chk("t6_pcen", pc_enable, 0);
    chk("t6_busy", fetch_busy, 0);
    redirect = 1'b0; halt = 1'b1; reset = 1'b1;
    tick();
    chk("t6_req_after", imem_req, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
